// File: rtl/winner_scan_nxn_pkg.sv
// Shared cell codes, FSM state type and line geometry for the N x N win scanner.
package winner_pkg;

  localparam logic [1:0] CELL_EMPTY   = 2'b00;
  localparam logic [1:0] CELL_PLAYER  = 2'b01;
  localparam logic [1:0] CELL_COMP    = 2'b10;
  localparam logic [1:0] CELL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic int num_lines(input int n);
    return 2 * n + 2;
  endfunction

  // Board cell index of the k-th cell along a line; lines are rows, columns, main diag, anti-diag.
  function automatic int cell_index(input int n, input int line, input int k);
    if (line < n)
      return line * n + k;
    else if (line < 2 * n)
      return k * n + (line - n);
    else if (line == 2 * n)
      return k * n + k;
    else
      return k * n + (n - 1 - k);
  endfunction

endpackage

// File: rtl/winner_scan_nxn_if.sv
// Request/result bundle between the game controller (master) and the win scanner (slave).
interface winner_scan_nxn_if #(
  parameter int N = 3
) ();
  localparam int LW = $clog2(winner_pkg::num_lines(N));

  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  logic              winner;
  logic [1:0]        who;
  logic [LW-1:0]     win_line;
  logic              draw;
  logic              error;

  modport master (
    output start, board,
    input  busy, done, winner, who, win_line, draw, error
  );

  modport slave (
    input  start, board,
    output busy, done, winner, who, win_line, draw, error
  );
endinterface

// File: rtl/winner_scan_nxn_line.sv
// Combinational check of one line of N cells: complete when every cell holds the same player code.
module winner_line_n
  import winner_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N-1:0] cells,
  output logic           win,
  output logic [1:0]     who
);

  logic [N-1:0] same;
  logic [1:0]   first;

  assign first = cells[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cmp
      assign same[gi] = (cells[2*gi +: 2] == first);
    end
  endgenerate

  // An all-11 or all-empty line is uniform but never a win.
  assign win = (&same) && ((first == CELL_PLAYER) || (first == CELL_COMP));
  assign who = win ? first : CELL_EMPTY;

endmodule

// File: rtl/winner_scan_nxn.sv
// Sequential N x N noughts-and-crosses detector: snapshots the board, then checks one line per clock.
module winner_scan_nxn
  import winner_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  winner_scan_nxn_if.slave bus
);

  localparam int L  = num_lines(N);
  localparam int LW = $clog2(L);
  localparam logic [LW-1:0] LAST_LINE = LW'(L - 1);

  state_t           state_reg;
  logic [2*N*N-1:0] snap_reg;
  logic [LW-1:0]    line_idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             winner_reg;
  logic [1:0]       who_reg;
  logic [LW-1:0]    win_line_reg;
  logic             draw_reg;
  logic             error_reg;

  logic [1:0]       cand [N][L];
  logic [2*N-1:0]   line_cells;
  logic             line_win;
  logic [1:0]       line_who;
  logic [N*N-1:0]   board_illegal;
  logic [N*N-1:0]   snap_empty;
  logic             board_err;
  logic             has_empty;

  genvar gi, gj;
  generate
    // Every line's k-th cell is wired statically; line_idx then picks one column of candidates.
    for (gi = 0; gi < N; gi++) begin : g_sel
      for (gj = 0; gj < L; gj++) begin : g_line
        localparam int CI = cell_index(N, gj, gi);
        assign cand[gi][gj] = snap_reg[2*CI +: 2];
      end
      assign line_cells[2*gi +: 2] = cand[gi][line_idx_reg];
    end

    for (gi = 0; gi < N * N; gi++) begin : g_cell
      assign board_illegal[gi] = (bus.board[2*gi +: 2] == CELL_ILLEGAL);
      assign snap_empty[gi]    = (snap_reg[2*gi +: 2] == CELL_EMPTY);
    end
  endgenerate

  assign board_err = |board_illegal;
  assign has_empty = |snap_empty;

  winner_line_n #(.N(N)) u_line (
    .cells (line_cells),
    .win   (line_win),
    .who   (line_who)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      snap_reg     <= '0;
      line_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      winner_reg   <= 1'b0;
      who_reg      <= CELL_EMPTY;
      win_line_reg <= '0;
      draw_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            snap_reg     <= bus.board;
            line_idx_reg <= '0;
            winner_reg   <= 1'b0;
            who_reg      <= CELL_EMPTY;
            win_line_reg <= '0;
            draw_reg     <= 1'b0;
            error_reg    <= board_err;
            busy_reg     <= 1'b1;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          if (line_win) begin
            winner_reg   <= 1'b1;
            who_reg      <= line_who;
            win_line_reg <= line_idx_reg;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else if (line_idx_reg == LAST_LINE) begin
            draw_reg  <= !has_empty && !error_reg;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            line_idx_reg <= line_idx_reg + 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.winner   = winner_reg;
  assign bus.who      = who_reg;
  assign bus.win_line = win_line_reg;
  assign bus.draw     = draw_reg;
  assign bus.error    = error_reg;

endmodule
